// File: rtl/puf_seq_ctrl.sv
// puf_seq_ctrl: UART command sequencer for a PUF evaluation engine.
// Decodes NOP/SEL/RUN/WAIT command bytes, requests evaluations and returns one byte per result.
module puf_seq_ctrl #(
  parameter int DP_WIDTH = 8,
  parameter int WAIT_W   = 8,
  parameter int TIMEOUT  = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DP_WIDTH-1:0] rx_data_i,
  input  logic                rx_valid_i,
  output logic [DP_WIDTH-1:0] tx_data_o,
  output logic                tx_valid_o,
  input  logic                tx_busy_i,
  output logic                puf_req_o,
  output logic [DP_WIDTH-1:0] puf_sel_o,
  output logic [WAIT_W-1:0]   puf_wait_cyc_o,
  input  logic                puf_busy_i,
  input  logic                puf_valid_i,
  input  logic [5:0]          puf_q_i,
  output logic                busy_o
);

  localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_SEL  = 2'b01;
  localparam logic [1:0] OP_RUN  = 2'b10;
  localparam logic [1:0] OP_WAIT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_RESP,
    S_TX,
    S_TX_HOLD,
    S_TX_WAIT
  } state_t;

  state_t              r_state;
  logic [DP_WIDTH-1:0] r_tx_data;
  logic [DP_WIDTH-1:0] r_tx_byte;
  logic                r_tx_valid;
  logic                r_puf_req;
  logic [DP_WIDTH-1:0] r_puf_sel;
  logic [WAIT_W-1:0]   r_wait_cyc;
  logic [5:0]          r_run_cnt;
  logic [TMO_W-1:0]    r_tmo;
  logic                r_is_run;

  logic [1:0] w_opcode;
  logic [5:0] w_arg;
  logic       w_tmo_expire;

  assign w_opcode = rx_data_i[7:6];
  assign w_arg    = rx_data_i[5:0];

  // The counter is 0 in the request-pulse cycle; expiry fires as it steps onto TIMEOUT-1,
  // so the error strobe lands exactly TIMEOUT cycles after the request pulse.
  assign w_tmo_expire = (r_tmo == TMO_W'(TIMEOUT - 2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_tx_data  <= '0;
      r_tx_byte  <= '0;
      r_tx_valid <= 1'b0;
      r_puf_req  <= 1'b0;
      r_puf_sel  <= '0;
      r_wait_cyc <= '0;
      r_run_cnt  <= '0;
      r_tmo      <= '0;
      r_is_run   <= 1'b0;
    end else begin
      r_tx_valid <= 1'b0;
      r_puf_req  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (rx_valid_i) begin
            r_tx_byte <= rx_data_i;
            case (w_opcode)
              OP_SEL: begin
                r_puf_sel <= DP_WIDTH'(w_arg);
                r_is_run  <= 1'b0;
                r_state   <= S_TX;
              end
              OP_WAIT: begin
                r_wait_cyc <= WAIT_W'(w_arg);
                r_is_run   <= 1'b0;
                r_state    <= S_TX;
              end
              OP_RUN: begin
                r_run_cnt <= w_arg;
                r_is_run  <= 1'b1;
                r_state   <= S_REQ;
              end
              OP_NOP: r_state <= S_IDLE;
              default: r_state <= S_IDLE;
            endcase
          end
        end

        S_REQ: begin
          if (!puf_busy_i) begin
            r_puf_req <= 1'b1;
            r_tmo     <= '0;
            r_state   <= S_WAIT_RESP;
          end
        end

        // A response arriving in the expiry cycle still wins over the error byte.
        S_WAIT_RESP: begin
          if (puf_valid_i) begin
            r_tx_byte <= DP_WIDTH'({2'b10, puf_q_i});
            r_state   <= S_TX;
          end else if (w_tmo_expire) begin
            r_tx_byte <= DP_WIDTH'(8'hEE);
            r_run_cnt <= '0;
            r_state   <= S_TX;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
        end

        S_TX: begin
          if (!tx_busy_i) begin
            r_tx_data  <= r_tx_byte;
            r_tx_valid <= 1'b1;
            r_state    <= S_TX_HOLD;
          end
        end

        S_TX_HOLD: r_state <= S_TX_WAIT;

        S_TX_WAIT: begin
          if (!tx_busy_i) begin
            if (r_is_run && (r_run_cnt != 6'd0)) begin
              r_run_cnt <= r_run_cnt - 6'd1;
              r_state   <= S_REQ;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tx_data_o      = r_tx_data;
  assign tx_valid_o     = r_tx_valid;
  assign puf_req_o      = r_puf_req;
  assign puf_sel_o      = r_puf_sel;
  assign puf_wait_cyc_o = r_wait_cyc;
  assign busy_o         = (r_state != S_IDLE);

endmodule

// File: tb/tb_puf_seq_ctrl.sv
// tb_puf_seq_ctrl: scoreboard bench for puf_seq_ctrl with PUF and UART responder models.
// Expected bytes are queued when a command is issued and popped whenever tx_valid_o strobes.
module tb_puf_seq_ctrl;
  localparam int DP_WIDTH = 8;
  localparam int WAIT_W   = 8;
  localparam int TIMEOUT  = 1024;
  localparam int IDLE_BOUND = 4000;

  typedef struct {
    logic [7:0] data;
    bit         isTimeout;
  } expByte_t;

  typedef struct {
    logic [5:0] q;
    int         delay;
  } plan_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [DP_WIDTH-1:0] rx_data_i = '0;
  logic                rx_valid_i = 1'b0;
  logic [DP_WIDTH-1:0] tx_data_o;
  logic                tx_valid_o;
  logic                tx_busy_i;
  logic                puf_req_o;
  logic [DP_WIDTH-1:0] puf_sel_o;
  logic [WAIT_W-1:0]   puf_wait_cyc_o;
  logic                puf_busy_i;
  logic                puf_valid_i;
  logic [5:0]          puf_q_i;
  logic                busy_o;

  logic uartBusy = 1'b0;
  logic forceBusy = 1'b0;
  assign tx_busy_i = uartBusy | forceBusy;

  expByte_t expQ[$];
  plan_t    planQ[$];
  expByte_t monE;
  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int lastReqCycle = 0;
  int txCount = 0;
  int reqCount = 0;
  int expReqs = 0;
  logic [7:0] lastTx = '0;
  logic [7:0] modelSel = '0;
  logic [7:0] modelWait = '0;
  bit prevTxValid = 1'b0;
  bit prevReq = 1'b0;

  puf_seq_ctrl #(.DP_WIDTH(DP_WIDTH), .WAIT_W(WAIT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_busy_i(tx_busy_i),
    .puf_req_o(puf_req_o), .puf_sel_o(puf_sel_o), .puf_wait_cyc_o(puf_wait_cyc_o),
    .puf_busy_i(puf_busy_i), .puf_valid_i(puf_valid_i), .puf_q_i(puf_q_i),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cycle);
    end
  endtask

  function automatic plan_t mkPlan(input logic [5:0] q, input int delay);
    plan_t p;
    p.q = q;
    p.delay = delay;
    return p;
  endfunction

  // Monitor: pops the scoreboard on every transmit strobe, checks hold and pulse widths.
  always @(negedge clk) begin
    cycle++;
    if (rst_n) begin
      if (puf_req_o) begin
        checkOutput("req_single_cycle", 32'(prevReq), 0);
        lastReqCycle = cycle;
      end
      if (tx_valid_o) begin
        txCount++;
        checkOutput("tx_single_cycle", 32'(prevTxValid), 0);
        checkOutput("tx_expected", 32'(expQ.size() > 0), 1);
        if (expQ.size() > 0) begin
          monE = expQ.pop_front();
          checkOutput("tx_data", 32'(tx_data_o), 32'(monE.data));
          lastTx = monE.data;
          if (monE.isTimeout) checkOutput("timeout_latency", cycle - lastReqCycle, TIMEOUT);
        end
      end else begin
        checkOutput("tx_data_hold", 32'(tx_data_o), 32'(lastTx));
      end
    end
    prevReq = puf_req_o;
    prevTxValid = tx_valid_o;
  end

  // PUF engine model: answers each request according to the next planned delay.
  initial begin
    plan_t p;
    bit spur;
    puf_busy_i = 1'b0;
    puf_valid_i = 1'b0;
    puf_q_i = '0;
    spur = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (spur) begin
        puf_valid_i = 1'b0;
        spur = 1'b0;
      end
      if (puf_req_o && rst_n) begin
        reqCount++;
        checkOutput("req_while_puf_busy", 32'(puf_busy_i), 0);
        checkOutput("req_planned", 32'(planQ.size() > 0), 1);
        if (planQ.size() > 0) begin
          p = planQ.pop_front();
          puf_busy_i = 1'b1;
          if (p.delay >= 0) begin
            repeat (p.delay) begin @(posedge clk); #1; end
            puf_valid_i = 1'b1;
            puf_q_i = p.q;
            @(posedge clk); #1;
            puf_valid_i = 1'b0;
            puf_q_i = 6'($urandom);
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          end else begin
            repeat (5) begin @(posedge clk); #1; end
          end
          puf_busy_i = 1'b0;
        end
      end else if (!busy_o && rst_n && $urandom_range(0, 7) == 0) begin
        puf_valid_i = 1'b1;
        puf_q_i = 6'($urandom);
        spur = 1'b1;
      end
    end
  end

  // UART transmitter model: busy for a few cycles after each strobe.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (tx_valid_o && rst_n) begin
        checkOutput("tx_while_busy", 32'(tx_busy_i), 0);
        uartBusy = 1'b1;
        repeat ($urandom_range(1, 6)) begin @(posedge clk); #1; end
        uartBusy = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic sendByte(input logic [7:0] b);
    rx_data_i = b;
    rx_valid_i = 1'b1;
    tick();
    rx_valid_i = 1'b0;
    rx_data_i = 8'($urandom);
  endtask

  // Reference model: SEL/WAIT echo the command; RUN n gives n+1 results, a late result ends the run with 0xEE.
  task automatic applyStimulus(input logic [7:0] cmd, input plan_t plans[$]);
    expByte_t e;
    plan_t p;
    int n;
    n = int'(cmd[5:0]);
    case (cmd[7:6])
      2'b01: begin
        modelSel = {2'b00, cmd[5:0]};
        e.data = cmd; e.isTimeout = 1'b0; expQ.push_back(e);
      end
      2'b11: begin
        modelWait = {2'b00, cmd[5:0]};
        e.data = cmd; e.isTimeout = 1'b0; expQ.push_back(e);
      end
      2'b10: begin
        for (int i = 0; i <= n; i++) begin
          if (i < plans.size()) p = plans[i];
          else p = mkPlan(6'($urandom), $urandom_range(0, 12));
          planQ.push_back(p);
          expReqs++;
          if (p.delay < 0 || p.delay > TIMEOUT - 2) begin
            e.data = 8'hEE; e.isTimeout = 1'b1; expQ.push_back(e);
            break;
          end
          e.data = 8'h80 + 8'(p.q); e.isTimeout = 1'b0; expQ.push_back(e);
        end
      end
      default: ;
    endcase
    sendByte(cmd);
    if (cmd[7:6] == 2'b01) checkOutput("sel_next_cycle", 32'(puf_sel_o), 32'(modelSel));
    if (cmd[7:6] == 2'b11) checkOutput("wait_next_cycle", 32'(puf_wait_cyc_o), 32'(modelWait));
  endtask

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    while ((busy_o || expQ.size() > 0) && n < IDLE_BOUND) begin
      tick();
      n++;
    end
    checkOutput({name, "_in_time"}, 32'(n < IDLE_BOUND), 1);
    checkOutput({name, "_busy_low"}, 32'(busy_o), 0);
    checkOutput({name, "_sel"}, 32'(puf_sel_o), 32'(modelSel));
    checkOutput({name, "_wait"}, 32'(puf_wait_cyc_o), 32'(modelWait));
    checkOutput({name, "_req_count"}, reqCount, expReqs);
    checkOutput({name, "_plan_used"}, planQ.size(), 0);
    tick();
  endtask

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    plan_t pl[$];
    plan_t none[$];
    logic [7:0] cmd;
    int t0;
    #3;
    checkOutput("rst_tx_valid", 32'(tx_valid_o), 0);
    checkOutput("rst_puf_req", 32'(puf_req_o), 0);
    checkOutput("rst_busy", 32'(busy_o), 0);
    checkOutput("rst_tx_data", 32'(tx_data_o), 0);
    checkOutput("rst_sel", 32'(puf_sel_o), 0);
    checkOutput("rst_wait", 32'(puf_wait_cyc_o), 0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;

    // First command right after release, then a single echo.
    t0 = txCount;
    applyStimulus(8'h45, none);
    waitIdle("sel45");
    checkOutput("sel45_single_strobe", txCount - t0, 1);

    applyStimulus(8'hD3, none);
    waitIdle("wait53");

    pl = {};
    pl.push_back(mkPlan(6'h2A, 4));
    pl.push_back(mkPlan(6'h15, 0));
    pl.push_back(mkPlan(6'h3F, 9));
    t0 = txCount;
    applyStimulus(8'h82, pl);
    waitIdle("run3");
    checkOutput("run3_strobes", txCount - t0, 3);

    pl = {};
    pl.push_back(mkPlan(6'h00, -1));
    applyStimulus(8'h80, pl);
    waitIdle("run_timeout");

    pl = {};
    pl.push_back(mkPlan(6'h11, TIMEOUT - 2));
    pl.push_back(mkPlan(6'h22, 3));
    applyStimulus(8'h81, pl);
    waitIdle("valid_at_expiry");

    pl = {};
    pl.push_back(mkPlan(6'h33, TIMEOUT - 1));
    applyStimulus(8'h85, pl);
    waitIdle("valid_too_late");

    forceBusy = 1'b1;
    t0 = txCount;
    applyStimulus(8'h5A, none);
    repeat (50) tick();
    checkOutput("held_no_strobe", txCount - t0, 0);
    forceBusy = 1'b0;
    waitIdle("tx_held");
    checkOutput("held_single_strobe", txCount - t0, 1);

    pl = {};
    for (int i = 0; i < 4; i++) pl.push_back(mkPlan(6'($urandom), 8));
    applyStimulus(8'h83, pl);
    repeat (3) tick();
    checkOutput("drop_while_busy", 32'(busy_o), 1);
    sendByte(8'hC7);
    waitIdle("run_with_drop");

    pl = {};
    pl.push_back(mkPlan(6'h00, -1));
    applyStimulus(8'h80, pl);
    repeat (10) tick();
    checkOutput("rst_mid_busy", 32'(busy_o), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_tx_valid", 32'(tx_valid_o), 0);
    checkOutput("rst_mid_puf_req", 32'(puf_req_o), 0);
    checkOutput("rst_mid_busy_low", 32'(busy_o), 0);
    checkOutput("rst_mid_tx_data", 32'(tx_data_o), 0);
    checkOutput("rst_mid_sel", 32'(puf_sel_o), 0);
    checkOutput("rst_mid_wait", 32'(puf_wait_cyc_o), 0);
    expQ = {};
    planQ = {};
    lastTx = '0;
    modelSel = '0;
    modelWait = '0;
    reqCount = 0;
    expReqs = 0;
    repeat (3) tick();
    rst_n = 1'b1;
    t0 = txCount;
    repeat (30) tick();
    checkOutput("rst_no_strobe", txCount - t0, 0);
    applyStimulus(8'h6B, none);
    waitIdle("sel_after_rst");

    for (int k = 0; k < 25; k++) begin
      cmd = 8'($urandom);
      pl = {};
      if (cmd[7:6] == 2'b10) begin
        cmd[5:0] = 6'($urandom_range(0, 6));
        for (int i = 0; i <= int'(cmd[5:0]); i++)
          pl.push_back(mkPlan(6'($urandom), ($urandom_range(0, 11) == 0) ? -1 : $urandom_range(0, 12)));
      end
      applyStimulus(cmd, pl);
      if (cmd[7:6] != 2'b00 && busy_o && $urandom_range(0, 2) == 0) sendByte(8'($urandom));
      waitIdle("random");
    end

    repeat (5) tick();
    checkOutput("final_expq_empty", expQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/puf_seq_ctrl.md
PUF_SEQ_CTRL -- requirements
Module: puf_seq_ctrl

Interface
REQ-001 Parameter DP_WIDTH, default 8: UART byte width and puf_sel_o width.
REQ-002 Parameter WAIT_W, default 8: width of puf_wait_cyc_o.
REQ-003 Parameter TIMEOUT, default 1024: cycles allowed from puf_req_o pulse to puf_valid_i.
REQ-004 clk  input  1  single clock (100 MHz domain); all logic on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 rx_data_i  input  DP_WIDTH  command byte from the UART receiver.
REQ-007 rx_valid_i  input  1  one-cycle strobe; rx_data_i valid.
REQ-008 tx_data_o  output  DP_WIDTH  byte to the UART transmitter.
REQ-009 tx_valid_o  output  1  one-cycle transmit strobe.
REQ-010 tx_busy_i  input  1  UART transmitter busy.
REQ-011 puf_req_o  output  1  one-cycle PUF evaluation request.
REQ-012 puf_sel_o  output  DP_WIDTH  PUF challenge select, registered.
REQ-013 puf_wait_cyc_o  output  WAIT_W  PUF settle-cycle count, registered.
REQ-014 puf_busy_i  input  1  PUF engine busy.
REQ-015 puf_valid_i  input  1  one-cycle strobe; puf_q_i valid.
REQ-016 puf_q_i  input  6  PUF response bits.
REQ-017 busy_o  output  1  high whenever the FSM is not in IDLE.

Function
REQ-018 Command byte decode, bits[7:6] opcode, bits[5:0] arg: 00 NOP, 01 SEL, 10 RUN, 11 WAIT.
REQ-019 NOP in IDLE: no action, no response byte.
REQ-020 SEL in IDLE: puf_sel_o <= zero-extended arg next cycle; then echo the command byte via TX.
REQ-021 WAIT in IDLE: puf_wait_cyc_o <= zero-extended arg next cycle; then echo the command byte via TX.
REQ-022 RUN in IDLE: load run counter with arg, perform arg+1 evaluations (1..64), one response byte per evaluation.
REQ-023 FSM states: IDLE, REQ, WAIT_RESP, TX, TX_HOLD, TX_WAIT.
REQ-024 IDLE->TX on SEL/WAIT; IDLE->REQ on RUN; NOP stays in IDLE.
REQ-025 REQ: pulse puf_req_o for exactly one cycle in the first cycle with puf_busy_i low, then go to WAIT_RESP and clear the timeout counter.
REQ-026 WAIT_RESP: on puf_valid_i, capture {2'b10, puf_q_i} as the TX byte, go to TX.
REQ-027 WAIT_RESP: when the timeout counter reaches TIMEOUT-1 without puf_valid_i, TX byte = 8'hEE, clear run counter, go to TX.
REQ-028 puf_valid_i in the same cycle as timeout expiry: valid wins; no error byte.
REQ-029 TX: in the first cycle with tx_busy_i low, drive tx_data_o and pulse tx_valid_o for one cycle, go to TX_HOLD.
REQ-030 TX_HOLD: one cycle, tx_busy_i ignored; then TX_WAIT.
REQ-031 TX_WAIT: wait for tx_busy_i low; then if the last op was RUN and run counter != 0, decrement and go to REQ; otherwise go to IDLE.
REQ-032 tx_data_o holds its last value between strobes.
REQ-033 rx_valid_i outside IDLE: byte dropped, no state change.
REQ-034 puf_valid_i outside WAIT_RESP: ignored.
REQ-035 Exactly one outstanding PUF request and one outstanding TX byte at any time.

Reset
REQ-036 rst_n low: state IDLE; tx_valid_o, puf_req_o, busy_o = 0; tx_data_o, puf_sel_o, puf_wait_cyc_o = 0; run and timeout counters = 0.
REQ-037 Reset mid-operation aborts the current op immediately; no partial strobe after release.
REQ-038 First command is accepted on the first clock edge after rst_n deasserts.

Verification
REQ-039 SEL 0x45 in IDLE -> puf_sel_o = 0x05 one cycle later; tx_data_o = 0x45 with a single tx_valid_o pulse.
REQ-040 RUN 0x82, puf returns Q = 0x2A, 0x15, 0x3F -> three puf_req_o pulses; bytes 0xAA, 0x95, 0xBF in order; busy_o low afterwards.
REQ-041 RUN 0x80, puf_valid_i never asserted -> 0xEE sent exactly TIMEOUT cycles after the req pulse; FSM returns to IDLE.
REQ-042 tx_busy_i held high 50 cycles during TX -> tx_valid_o held off until busy falls; exactly one strobe.
REQ-043 WAIT 0xC7 sent while a RUN is in progress -> byte dropped; puf_wait_cyc_o unchanged; RUN completes normally.
REQ-044 rst_n pulsed low in WAIT_RESP -> all outputs zero; no tx_valid_o after release; next SEL is handled normally.
